// File: rtl/spi_slave_frame.sv
// -----------------------------------------------------------------------------
// spi_slave_frame
//
// SPI slave that moves fixed-length frames of WIDTH bits. All SPI inputs are
// oversampled in the clk domain; clk must run at least 4x faster than sclk.
//
// Parameters
//   WIDTH : bits per frame (8..64)
//   CPOL  : sclk idle level
//   CPHA  : 0 = sample on leading edge, 1 = sample on trailing edge
//
// Ports
//   clk, rstn          : system clock, asynchronous active-low reset
//   sclk, cs_n, mosi   : SPI bus from the master (asynchronous to clk)
//   miso               : SPI data to the master (registered)
//   tx_data/tx_valid   : next frame to transmit, loaded into a holding buffer
//   tx_ready           : holding buffer is empty
//   rx_data/rx_valid   : last received frame, held until rx_ready
//   rx_ready           : consumer accepts rx_data
//   overrun            : sticky, a complete frame was dropped (rx_valid high)
//   overrun_clr        : clears overrun (a same-cycle new overrun wins)
//   frame_err          : one-cycle pulse, cs_n released mid-frame
//
// Build option
//   SPI_LSB_FIRST_EN : when defined, bit 0 is sent and received first;
//                      otherwise bit WIDTH-1 goes first.
// -----------------------------------------------------------------------------
module spi_slave_frame #(
    parameter int WIDTH = 40,
    parameter bit CPOL  = 1'b0,
    parameter bit CPHA  = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             frame_err
);

`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    // ---------------------------------------------------------------- state
    state_e           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;

    logic             sclk_s1_q,   sclk_s1_d;
    logic             sclk_s2_q,   sclk_s2_d;
    logic             sclk_prev_q, sclk_prev_d;
    logic             cs_s1_q,     cs_s1_d;
    logic             cs_s2_q,     cs_s2_d;
    logic             cs_prev_q,   cs_prev_d;
    logic             mosi_s1_q,   mosi_s1_d;
    logic             mosi_s2_q,   mosi_s2_d;

    logic [WIDTH-1:0] rx_sr_q,     rx_sr_d;
    logic [WIDTH-1:0] tx_sr_q,     tx_sr_d;
    logic [WIDTH-1:0] tx_buf_q,    tx_buf_d;
    logic             tx_full_q,   tx_full_d;

    logic [WIDTH-1:0] rx_data_q,   rx_data_d;
    logic             rx_valid_q,  rx_valid_d;
    logic             overrun_q,   overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             miso_q,      miso_d;

    // ------------------------------------------------------ edge detection
    logic sclk_rise, sclk_fall;
    logic lead_edge, trail_edge;
    logic sample_edge, shift_edge;
    logic cs_fall;

    always_comb begin
        sclk_s1_d   = sclk;
        sclk_s2_d   = sclk_s1_q;
        sclk_prev_d = sclk_s2_q;
        cs_s1_d     = cs_n;
        cs_s2_d     = cs_s1_q;
        cs_prev_d   = cs_s2_q;
        mosi_s1_d   = mosi;
        mosi_s2_d   = mosi_s1_q;

        sclk_rise   = sclk_s2_q & ~sclk_prev_q;
        sclk_fall   = ~sclk_s2_q & sclk_prev_q;
        lead_edge   = CPOL ? sclk_fall : sclk_rise;
        trail_edge  = CPOL ? sclk_rise : sclk_fall;
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge  : trail_edge;
        cs_fall     = cs_prev_q & ~cs_s2_q;
    end

    // ----------------------------------------------------- shift functions
    logic [WIDTH-1:0] rx_shifted;
    logic [WIDTH-1:0] tx_shifted;

    always_comb begin
        if (LSB_FIRST) begin
            rx_shifted = {mosi_s2_q, rx_sr_q[WIDTH-1:1]};
            tx_shifted = {1'b0, tx_sr_q[WIDTH-1:1]};
        end else begin
            rx_shifted = {rx_sr_q[WIDTH-2:0], mosi_s2_q};
            tx_shifted = {tx_sr_q[WIDTH-2:0], 1'b0};
        end
    end

    // ------------------------------------------------ FSM and datapath
    logic reload;
    logic frame_done;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        reload      = 1'b0;
        frame_done  = 1'b0;

        // Consumer handshake and sticky-flag clear; a completing frame below
        // may override both in the same cycle.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        // Holding buffer load; only possible while empty, so it never
        // collides with a transfer into the shift register.
        if (tx_valid && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cs_fall) begin
                    state_d = SHIFT;
                    reload  = 1'b1;
                end
            end

            SHIFT: begin
                if (cs_s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rx_sr_d = '0;
                    if (cnt_q != '0) begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    // A shift edge with the counter at 0 is either the
                    // trailing edge that closes the previous frame (CPHA=0)
                    // or the first leading edge (CPHA=1); in both cases the
                    // current first bit must stay on miso.
                    if (shift_edge && (cnt_q != '0)) begin
                        tx_sr_d = tx_shifted;
                    end
                    if (sample_edge) begin
                        rx_sr_d = rx_shifted;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            frame_done = 1'b1;
                            reload     = 1'b1;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame delivery: accepted when the slot is free or being freed
        // this very cycle; otherwise the new frame is dropped.
        if (frame_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_sr_d;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (reload) begin
            if (tx_full_q) begin
                tx_sr_d   = tx_buf_q;
                tx_full_d = 1'b0;
            end else begin
                tx_sr_d = '0;
            end
        end

        if (state_d == SHIFT) begin
            miso_d = LSB_FIRST ? tx_sr_d[0] : tx_sr_d[WIDTH-1];
        end else begin
            miso_d = 1'b0;
        end
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            cs_prev_q   <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sclk_s1_q   <= sclk_s1_d;
            sclk_s2_q   <= sclk_s2_d;
            sclk_prev_q <= sclk_prev_d;
            cs_s1_q     <= cs_s1_d;
            cs_s2_q     <= cs_s2_d;
            cs_prev_q   <= cs_prev_d;
            mosi_s1_q   <= mosi_s1_d;
            mosi_s2_q   <= mosi_s2_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
        end
    end

    // ------------------------------------------------------------- outputs
    assign miso      = miso_q;
    assign tx_ready  = ~tx_full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_frame.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_frame
//
// Four spi_slave_frame instances (WIDTH=40), one per SPI mode (index =
// CPOL*2+CPHA), each with its own sclk/cs_n. A bench SPI master drives frames;
// expected received frames go into a scoreboard queue and are checked by a
// monitor whenever an rx_valid rises. miso words are checked inline.
// -----------------------------------------------------------------------------
module tb_spi_slave_frame;

    localparam int W = 40;
    localparam int H = 8;   // sclk half period in clk cycles

    logic           clk;
    logic           rstn;
    logic           mosi;
    logic [W-1:0]   tx_data;
    logic [3:0]     sclk_v, cs_n_v, miso_v, tx_valid_v, tx_ready_v;
    logic [3:0]     rx_valid_v, rx_ready_v, overrun_v, overrun_clr_v, frame_err_v;
    logic [W-1:0]   rx_data_v [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_frame #(
            .WIDTH (W),
            .CPOL  ((g / 2) == 1),
            .CPHA  ((g % 2) == 1)
        ) u_dut (
            .clk         (clk),
            .rstn        (rstn),
            .sclk        (sclk_v[g]),
            .cs_n        (cs_n_v[g]),
            .mosi        (mosi),
            .miso        (miso_v[g]),
            .tx_data     (tx_data),
            .tx_valid    (tx_valid_v[g]),
            .tx_ready    (tx_ready_v[g]),
            .rx_data     (rx_data_v[g]),
            .rx_valid    (rx_valid_v[g]),
            .rx_ready    (rx_ready_v[g]),
            .overrun     (overrun_v[g]),
            .overrun_clr (overrun_clr_v[g]),
            .frame_err   (frame_err_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ checking
    int checks = 0;
    int errors = 0;

    typedef struct {
        int           mode;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int   rx_rises [4] = '{default: 0};
    int   fe_cycles[4] = '{default: 0};
    int   txr_low  [4] = '{default: 0};
    logic [3:0] rxv_prev = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rx_valid_v[m] && !rxv_prev[m]) begin
                rx_rises[m]++;
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL rx_unexpected: observed mode %0d data=0x%0h expected no frame",
                           m, rx_data_v[m]);
                end
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rx_mode", 64'(m), 64'(e.mode));
                    chk($sformatf("rx_data_m%0d", m), 64'(rx_data_v[m]), 64'(e.data));
                end
            end
            if (frame_err_v[m]) fe_cycles[m]++;
            if (!tx_ready_v[m]) txr_low[m]++;
        end
        rxv_prev <= rx_valid_v;
    end

    // --------------------------------------------------------- SPI master
    task automatic cs_assert(input int m);
        @(negedge clk);
        cs_n_v[m] = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_release(input int m);
        @(negedge clk);
        cs_n_v[m] = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    // MSB-first transfer of nbits bits; returns the bits captured on miso.
    task automatic spi_xfer(input int m, input logic [W-1:0] word, input int nbits,
                            output logic [W-1:0] got);
        logic cpol;
        logic cpha;
        cpol = (m >= 2);
        cpha = (m % 2) == 1;
        got  = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = W - 1 - i;
            if (!cpha) begin
                mosi = word[idx];
                repeat (H) @(negedge clk);
                sclk_v[m] = ~cpol;
                got[idx] = miso_v[m];
                repeat (H) @(negedge clk);
                sclk_v[m] = cpol;
            end else begin
                sclk_v[m] = ~cpol;
                mosi = word[idx];
                repeat (H) @(negedge clk);
                sclk_v[m] = cpol;
                got[idx] = miso_v[m];
                repeat (H) @(negedge clk);
            end
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic load_tx(input int m, input logic [W-1:0] d);
        @(negedge clk);
        tx_data       = d;
        tx_valid_v[m] = 1'b1;
        @(negedge clk);
        tx_valid_v[m] = 1'b0;
    endtask

    task automatic push_exp(input int m, input logic [W-1:0] d);
        exp_t e;
        e.mode = m;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_reset(input int m, input string tag);
        chk({tag, "_miso"},      64'(miso_v[m]),      64'd0);
        chk({tag, "_rx_valid"},  64'(rx_valid_v[m]),  64'd0);
        chk({tag, "_overrun"},   64'(overrun_v[m]),   64'd0);
        chk({tag, "_frame_err"}, 64'(frame_err_v[m]), 64'd0);
        chk({tag, "_tx_ready"},  64'(tx_ready_v[m]),  64'd1);
        chk({tag, "_rx_data"},   64'(rx_data_v[m]),   64'd0);
    endtask

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ----------------------------------------------------------- stimulus
    initial begin
        logic [W-1:0] got;
        int rises_snap;
        int fe_snap;
        int txr_snap;

        rstn          = 1'b0;
        mosi          = 1'b0;
        tx_data       = '0;
        sclk_v        = 4'b1100;
        cs_n_v        = 4'b1111;
        tx_valid_v    = '0;
        rx_ready_v    = 4'b1111;
        overrun_clr_v = '0;

        repeat (5) @(negedge clk);
        check_reset(0, "reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame with preloaded TX word
        load_tx(0, 40'h00_DEAD_BEEF);
        chk("tx_ready_after_load", 64'(tx_ready_v[0]), 64'd0);
        cs_assert(0);
        chk("tx_ready_after_start", 64'(tx_ready_v[0]), 64'd1);
        push_exp(0, 40'hA5_1234_5678);
        spi_xfer(0, 40'hA5_1234_5678, W, got);
        cs_release(0);
        chk("miso_basic", 64'(got), 64'h00_DEAD_BEEF);
        chk("rx_rises_basic", 64'(rx_rises[0]), 64'd1);
        chk("rx_data_basic", 64'(rx_data_v[0]), 64'hA5_1234_5678);
        chk("rx_valid_consumed", 64'(rx_valid_v[0]), 64'd0);

        // No TX load: master reads zeros, tx_ready never drops
        txr_snap = txr_low[0];
        cs_assert(0);
        push_exp(0, 40'h12_3456_789A);
        spi_xfer(0, 40'h12_3456_789A, W, got);
        cs_release(0);
        chk("miso_no_load", 64'(got), 64'd0);
        chk("tx_ready_low_cycles", 64'(txr_low[0] - txr_snap), 64'd0);

        // Back-to-back frames with consumer stalled -> overrun
        rx_ready_v[0] = 1'b0;
        cs_assert(0);
        push_exp(0, 40'h11_1111_1111);
        spi_xfer(0, 40'h11_1111_1111, W, got);
        spi_xfer(0, 40'h22_2222_2222, W, got);
        cs_release(0);
        chk("ovr_rx_data", 64'(rx_data_v[0]), 64'h11_1111_1111);
        chk("ovr_rx_valid", 64'(rx_valid_v[0]), 64'd1);
        chk("ovr_flag", 64'(overrun_v[0]), 64'd1);
        @(negedge clk);
        overrun_clr_v[0] = 1'b1;
        @(negedge clk);
        overrun_clr_v[0] = 1'b0;
        chk("ovr_cleared", 64'(overrun_v[0]), 64'd0);
        chk("ovr_rx_valid_held", 64'(rx_valid_v[0]), 64'd1);
        rx_ready_v[0] = 1'b1;
        @(negedge clk);
        chk("ovr_rx_valid_drained", 64'(rx_valid_v[0]), 64'd0);

        // cs_n released after 17 bits -> frame_err, then a clean frame
        rises_snap = rx_rises[0];
        fe_snap    = fe_cycles[0];
        cs_assert(0);
        spi_xfer(0, 40'hFF_FFFF_FFFF, 17, got);
        cs_release(0);
        chk("frame_err_cycles", 64'(fe_cycles[0] - fe_snap), 64'd1);
        chk("frame_err_no_rx", 64'(rx_rises[0] - rises_snap), 64'd0);
        chk("frame_err_rx_valid", 64'(rx_valid_v[0]), 64'd0);
        chk("frame_err_rx_data", 64'(rx_data_v[0]), 64'h11_1111_1111);
        cs_assert(0);
        push_exp(0, 40'hC3_C3C3_C3C3);
        spi_xfer(0, 40'hC3_C3C3_C3C3, W, got);
        cs_release(0);
        chk("after_err_rx_data", 64'(rx_data_v[0]), 64'hC3_C3C3_C3C3);

        // Reset at bit 20 with a word waiting in the TX buffer
        fe_snap = fe_cycles[0];
        cs_assert(0);
        load_tx(0, 40'h77_7777_7777);
        spi_xfer(0, 40'h3C_3C3C_3C3C, 20, got);
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset(0, "midreset");
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        cs_release(0);
        chk("midreset_no_frame_err", 64'(fe_cycles[0] - fe_snap), 64'd0);
        cs_assert(0);
        push_exp(0, 40'h69_8765_4321);
        spi_xfer(0, 40'h69_8765_4321, W, got);
        cs_release(0);
        chk("after_reset_miso", 64'(got), 64'd0);
        chk("after_reset_rx_data", 64'(rx_data_v[0]), 64'h69_8765_4321);

        // Modes 1, 2, 3
        for (int m = 1; m < 4; m++) begin
            load_tx(m, 40'h01_2345_6789);
            cs_assert(m);
            push_exp(m, 40'h5A_5A5A_5A5A);
            spi_xfer(m, 40'h5A_5A5A_5A5A, W, got);
            cs_release(m);
            chk($sformatf("mode%0d_miso", m), 64'(got), 64'h01_2345_6789);
            chk($sformatf("mode%0d_rx_data", m), 64'(rx_data_v[m]), 64'h5A_5A5A_5A5A);
            chk($sformatf("mode%0d_rx_rises", m), 64'(rx_rises[m]), 64'd1);
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
